prog_pkt_tx: RTL and testbench

- Framed byte-stream transmitter for the UART program-load protocol.
- Reads a block of 32-bit words from a memory read port and emits them as one frame: SOP, CMD, LEN_LB, LEN_HB, data bytes, checksum, EOP.
- Then optionally waits for the single-byte ACK returned by the loader.
- Sits between a word source (RAM/ROM dump port) and the uart_tx byte interface; used for readback (cmd 0x08) and board-to-board program push (cmd 0x07).

---
 rtl/prog_pkt_tx.sv | 218 +++++++++++++++++++++
 tb/tb_prog_pkt_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_pkt_tx.sv
// Framed byte-stream transmitter for the UART program-load protocol.
// Fetches a block of 32-bit words from a read port and emits
// SOP, CMD, LEN_LB, LEN_HB, data bytes (little-endian), checksum, EOP.
// It then optionally waits for a one-byte response from the loader.
module prog_pkt_tx #(
    parameter logic [7:0]       SOP         = 8'h23,
    parameter logic [7:0]       EOP         = 8'h0D,
    parameter logic [7:0]       ACK         = 8'h55,
    parameter bit               WAIT_ACK    = 1'b1,
    parameter int               TMO_W       = 24,
    parameter logic [TMO_W-1:0] ACK_TIMEOUT = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [15:0] len,
    input  logic [15:0] base_addr,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        ack_ok,
    output logic [7:0]  ack_byte,
    output logic        timeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_SOP, S_CMD, S_LEN_LB, S_LEN_HB, S_FETCH, S_FETCH_W,
        S_DATA, S_CS, S_EOP, S_ACK_WAIT, S_DONE
    } state_t;

    // Last cycle of the response window.
    localparam logic [TMO_W-1:0] TMO_LAST = ACK_TIMEOUT - TMO_W'(1);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       base_q, base_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        cs_q, cs_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              ack_ok_q, ack_ok_d;
    logic [7:0]        ack_byte_q, ack_byte_d;
    logic              timeout_q, timeout_d;

    logic              tx_valid_s;
    logic [7:0]        tx_data_s;
    logic              accept_s;

    // Byte presented to the UART, decoded purely from registered state.
    always_comb begin
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
        case (state_q)
            S_SOP:    begin tx_valid_s = 1'b1; tx_data_s = SOP;          end
            S_CMD:    begin tx_valid_s = 1'b1; tx_data_s = cmd_q;        end
            S_LEN_LB: begin tx_valid_s = 1'b1; tx_data_s = len_q[7:0];   end
            S_LEN_HB: begin tx_valid_s = 1'b1; tx_data_s = len_q[15:8];  end
            S_DATA:   begin tx_valid_s = 1'b1; tx_data_s = word_q[{byte_idx_q, 3'b000} +: 8]; end
            S_CS:     begin tx_valid_s = 1'b1; tx_data_s = cs_q;         end
            S_EOP:    begin tx_valid_s = 1'b1; tx_data_s = EOP;          end
            default:  begin tx_valid_s = 1'b0; tx_data_s = 8'h00;        end
        endcase
    end

    assign accept_s = tx_valid_s & tx_ready;

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        base_d     = base_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        cs_d       = cs_q;
        tmo_d      = tmo_q;
        ack_ok_d   = ack_ok_q;
        ack_byte_d = ack_byte_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d      = cmd;
                    len_d      = len;
                    base_d     = base_addr;
                    cs_d       = 8'h00;
                    word_cnt_d = 16'h0000;
                    byte_idx_d = 2'd0;
                    ack_ok_d   = 1'b0;
                    ack_byte_d = 8'h00;
                    timeout_d  = 1'b0;
                    state_d    = S_SOP;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_SOP:    if (accept_s) state_d = S_CMD;    else state_d = S_SOP;
            S_CMD:    if (accept_s) state_d = S_LEN_LB; else state_d = S_CMD;
            S_LEN_LB: if (accept_s) state_d = S_LEN_HB; else state_d = S_LEN_LB;
            S_LEN_HB: begin
                if (accept_s) begin
                    state_d = (len_q == 16'h0000) ? S_CS : S_FETCH;
                end else begin
                    state_d = S_LEN_HB;
                end
            end
            S_FETCH: state_d = S_FETCH_W;
            S_FETCH_W: begin
                // Read data is valid exactly one cycle after the strobe.
                word_d     = mem_rdata;
                byte_idx_d = 2'd0;
                state_d    = S_DATA;
            end
            S_DATA: begin
                if (accept_s) begin
                    cs_d       = cs_q + tx_data_s;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        word_cnt_d = word_cnt_q + 16'd1;
                        state_d    = ((word_cnt_q + 16'd1) == len_q) ? S_CS : S_FETCH;
                    end else begin
                        state_d    = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CS: if (accept_s) state_d = S_EOP; else state_d = S_CS;
            S_EOP: begin
                if (accept_s) begin
                    tmo_d = {TMO_W{1'b0}};
                    if (WAIT_ACK) begin
                        state_d    = S_ACK_WAIT;
                    end else begin
                        ack_ok_d   = 1'b1;
                        ack_byte_d = ACK;
                        timeout_d  = 1'b0;
                        state_d    = S_DONE;
                    end
                end else begin
                    state_d = S_EOP;
                end
            end
            S_ACK_WAIT: begin
                // A byte arriving on the expiry cycle still counts as a response.
                if (rx_valid) begin
                    ack_byte_d = rx_data;
                    ack_ok_d   = (rx_data == ACK);
                    timeout_d  = 1'b0;
                    state_d    = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    ack_byte_d = 8'h00;
                    ack_ok_d   = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    tmo_d      = tmo_q + TMO_W'(1);
                    state_d    = S_ACK_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= 8'h00;
            len_q      <= 16'h0000;
            base_q     <= 16'h0000;
            word_cnt_q <= 16'h0000;
            byte_idx_q <= 2'd0;
            word_q     <= 32'h0000_0000;
            cs_q       <= 8'h00;
            tmo_q      <= {TMO_W{1'b0}};
            ack_ok_q   <= 1'b0;
            ack_byte_q <= 8'h00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            base_q     <= base_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            cs_q       <= cs_d;
            tmo_q      <= tmo_d;
            ack_ok_q   <= ack_ok_d;
            ack_byte_q <= ack_byte_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_valid = tx_valid_s;
    assign tx_data  = tx_data_s;
    assign mem_rd   = (state_q == S_FETCH);
    assign mem_addr = mem_rd ? (base_q + word_cnt_q) : 16'h0000;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign ack_ok   = ack_ok_q;
    assign ack_byte = ack_byte_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_prog_pkt_tx.sv
// Self-checking bench for prog_pkt_tx: scoreboard of expected bytes and
// read addresses, filled when a frame is launched and drained by a monitor.
module tb_prog_pkt_tx;

    localparam logic [7:0] SOPB = 8'h23;
    localparam logic [7:0] EOPB = 8'h0D;

    logic        clk = 1'b0;
    logic        reset, start, tx_ready, rx_valid;
    logic [7:0]  cmd, rx_data;
    logic [15:0] len, base_addr;
    logic        mem_rd, tx_valid, busy, done, ack_ok, timeout;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_data, ack_byte;

    logic [31:0] mem [65536];
    logic [7:0]  exp_q[$];
    logic [15:0] addr_q[$];
    logic [7:0]  hist[$];

    int tests_run = 0;
    int fails     = 0;
    int acc_cnt   = 0;
    int rd_cnt    = 0;
    int done_cnt  = 0;
    bit hold_v    = 1'b0;
    logic [7:0] hold_d = 8'h00;

    int f_k;
    int f_rds;

    prog_pkt_tx #(.ACK_TIMEOUT(24'd100)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .len(len),
        .base_addr(base_addr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .done(done), .ack_ok(ack_ok), .ack_byte(ack_byte),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Read port model: data valid exactly one cycle after the strobe.
    always @(posedge clk) begin
        mem_rdata <= mem_rd ? mem[mem_addr] : 32'hDEAD_BEEF;
    end

    // Monitor: drains the byte/address scoreboards and checks hold stability.
    always @(negedge clk) begin : mon
        logic [7:0]  e;
        logic [15:0] ea;
        if (tx_valid && hold_v) begin
            tests_run++;
            if (tx_data !== hold_d) begin
                fails++;
                $display("FAIL tx_hold: tx_data %h changed, required %h", tx_data, hold_d);
            end
        end
        hold_v = tx_valid && !tx_ready;
        hold_d = tx_data;
        if (!reset && tx_valid && tx_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tx_extra: unexpected byte %h", tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    fails++;
                    $display("FAIL tx_byte: got %h, required %h", tx_data, e);
                end
            end
            acc_cnt++;
            hist.push_back(tx_data);
        end
        if (!reset && mem_rd) begin
            rd_cnt++;
            tests_run++;
            if (addr_q.size() == 0) begin
                fails++;
                $display("FAIL mem_rd_extra: unexpected read at %h", mem_addr);
            end else begin
                ea = addr_q.pop_front();
                if (mem_addr !== ea) begin
                    fails++;
                    $display("FAIL mem_addr: got %h, required %h", mem_addr, ea);
                end
            end
        end
        if (!reset && done) done_cnt++;
    end

    // Launch one frame, build its expected stream, and run it to done.
    task automatic run_frame(input logic [7:0] c, input logic [15:0] n, input logic [15:0] b,
                             input bit respond, input logic [7:0] resp, input bit bp, input bit spur);
        logic [7:0]  cs;
        logic [15:0] a;
        logic [31:0] w;
        int k, rd_base, done_base, cyc;
        bit eop_seen;
        cs = 8'h00;
        hist.delete();
        exp_q.push_back(SOPB);
        exp_q.push_back(c);
        exp_q.push_back(n[7:0]);
        exp_q.push_back(n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            a = b + 16'(i);
            addr_q.push_back(a);
            w = mem[a];
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back(w[8*j +: 8]);
                cs = cs + w[8*j +: 8];
            end
        end
        exp_q.push_back(cs);
        exp_q.push_back(EOPB);
        rd_base   = rd_cnt;
        done_base = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; cmd = c; len = n; base_addr = b;
        @(posedge clk); #1;
        start = 1'b0; cmd = 8'hEE; len = 16'hFFFF; base_addr = 16'hAAAA;
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b, required 1", busy);
        end
        eop_seen = 1'b0;
        k = 0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            tx_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            start    = spur && (cyc == 8);
            rx_valid = 1'b0;
            if (!eop_seen && exp_q.size() == 0) begin
                eop_seen = 1'b1;
                k = 0;
                if (respond) begin
                    rx_valid = 1'b1;
                    rx_data  = resp;
                end
            end else if (eop_seen) begin
                k++;
            end
            if (done) break;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; start = 1'b0; tx_ready = 1'b1;
        f_k   = k;
        f_rds = rd_cnt - rd_base;
        tests_run++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL frame_done: no done within budget, pending bytes %0d", exp_q.size());
        end
        tests_run++;
        if (addr_q.size() != 0) begin
            fails++;
            $display("FAIL mem_reads: %0d reads missing", addr_q.size());
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || (done_cnt - done_base) != 1) begin
            fails++;
            $display("FAIL frame_end: busy %b done %b pulses %0d, required 0 0 1",
                     busy, done, done_cnt - done_base);
        end
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic test_reset();
        tests_run++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_rd !== 1'b0 ||
            ack_ok !== 1'b0 || ack_byte !== 8'h00 || timeout !== 1'b0 ||
            tx_data !== 8'h00 || mem_addr !== 16'h0000) begin
            fails++;
            $display("FAIL reset_state: valid %b busy %b done %b rd %b ok %b byte %h tmo %b, required all 0",
                     tx_valid, busy, done, mem_rd, ack_ok, ack_byte, timeout);
        end
    endtask

    task automatic test_basic();
        mem[16'h0010] = 32'h0000_0093;
        run_frame(8'h07, 16'd1, 16'h0010, 1'b1, 8'h55, 1'b0, 1'b0);
        tests_run++;
        if (ack_ok !== 1'b1 || ack_byte !== 8'h55 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL basic_status: ok %b byte %h tmo %b, required 1 55 0", ack_ok, ack_byte, timeout);
        end
        tests_run++;
        if (hist.size() != 10 || hist[8] !== 8'h93) begin
            fails++;
            $display("FAIL basic_len_cs: %0d bytes, required 10 with checksum 93", hist.size());
        end
    endtask

    task automatic test_len0();
        run_frame(8'h08, 16'd0, 16'h1234, 1'b1, 8'h55, 1'b0, 1'b0);
        tests_run++;
        if (f_rds != 0 || hist.size() != 6) begin
            fails++;
            $display("FAIL len0: reads %0d bytes %0d, required 0 6", f_rds, hist.size());
        end
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 32'hFFFF_FFFF;
        mem[16'h0000] = 32'h0000_0002;
        run_frame(8'h07, 16'd2, 16'hFFFF, 1'b1, 8'h55, 1'b0, 1'b0);
        tests_run++;
        if (hist.size() != 14 || hist[12] !== 8'hFE || f_rds != 2) begin
            fails++;
            $display("FAIL wrap_checksum: bytes %0d reads %0d, required 14 bytes, cs FE, 2 reads",
                     hist.size(), f_rds);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) mem[16'h0100 + 16'(i)] = $urandom;
        run_frame(8'h07, 16'd3, 16'h0100, 1'b1, 8'h55, 1'b1, 1'b0);
        tests_run++;
        if (hist.size() != 18 || ack_ok !== 1'b1) begin
            fails++;
            $display("FAIL backpressure: bytes %0d ok %b, required 18 1", hist.size(), ack_ok);
        end
    endtask

    task automatic test_nak();
        mem[16'h0300] = 32'h1234_5678;
        run_frame(8'h07, 16'd1, 16'h0300, 1'b1, 8'hA5, 1'b0, 1'b0);
        tests_run++;
        if (ack_ok !== 1'b0 || ack_byte !== 8'hA5 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL nak_status: ok %b byte %h tmo %b, required 0 A5 0", ack_ok, ack_byte, timeout);
        end
    endtask

    task automatic test_timeout();
        run_frame(8'h08, 16'd1, 16'h0300, 1'b0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (f_k != 100) begin
            fails++;
            $display("FAIL timeout_latency: done %0d cycles after ACK_WAIT, required 100", f_k);
        end
        tests_run++;
        if (timeout !== 1'b1 || ack_ok !== 1'b0 || ack_byte !== 8'h00) begin
            fails++;
            $display("FAIL timeout_status: tmo %b ok %b byte %h, required 1 0 00", timeout, ack_ok, ack_byte);
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc_base, done_base;
        bit hit;
        mem[16'h0200] = 32'h4433_2211;
        acc_base = acc_cnt;
        hit = 1'b0;
        exp_q.push_back(SOPB); exp_q.push_back(8'h07); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        addr_q.push_back(16'h0200);
        @(posedge clk); #1;
        start = 1'b1; cmd = 8'h07; len = 16'd1; base_addr = 16'h0200;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (acc_cnt == acc_base + 6 && tx_valid) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (!hit || tx_data !== 8'h33) begin
            fails++;
            $display("FAIL mid_frame_byte2: reached %b data %h, required 1 33", hit, tx_data);
        end
        done_base = done_cnt;
        reset = 1'b1; tx_ready = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_frame_reset: valid %b busy %b, required 0 0", tx_valid, busy);
        end
        reset = 1'b0; tx_ready = 1'b1;
        exp_q.delete(); addr_q.delete();
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt != done_base || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_frame_no_done: pulses %0d busy %b, required 0 0", done_cnt - done_base, busy);
        end
        // Fresh frame, with a stray start pulse while busy that must be ignored.
        mem[16'h0201] = 32'hCAFE_F00D;
        run_frame(8'h07, 16'd2, 16'h0200, 1'b1, 8'h55, 1'b0, 1'b1);
        tests_run++;
        if (hist.size() != 14 || ack_ok !== 1'b1) begin
            fails++;
            $display("FAIL recovery_frame: bytes %0d ok %b, required 14 1", hist.size(), ack_ok);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_while_busy: busy %b after frame, required 0", busy);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cmd = 8'h00; len = 16'h0000; base_addr = 16'h0000;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_backpressure();
        test_nak();
        test_timeout();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
